sdram_page_reader: RTL
======================

// Module: sdram_page_reader
// PURPOSE
//  Read-side page negotiator for the SDRAM path. It issues page-read commands to
//  sdramctrl for one image frame, starting at a host-supplied row, and buffers the
//  returned 16-bit words in an on-chip FWFT FIFO. It presents those words to the
//  host-side pipe over a valid/ready handshake. Single clock (controller clock);
//  any CDC to the host clock is done downstream.
// PARAMETERS
//  PAGE_WORDS  512  words returned per page read (power of 2)
//  ROW_W       15   row address width
//  FIFO_AW     11   log2 FIFO depth (2048 words)
// PORTS
//  clk             in   1          controller clock, all logic on rising edge
//  reset           in   1          synchronous, active-high
//  frame_start     in   1          pulse: latch start_row/frame_pages, begin frame
//  start_row       in   ROW_W      first row of frame
//  frame_pages     in   16         pages in frame
//  rd_enable       in   1          permit new page requests
//  cmd_pageread    out  1          page-read request to sdramctrl
//  cmd_ack         in   1          controller accepted request
//  cmd_done        in   1          controller finished current page
//  rowaddr         out  ROW_W      row for current request
//  ctrl_fifo_write in   1          controller data strobe
//  ctrl_fifo_din   in   16         controller data
//  out_valid       out  1          out_data valid
//  out_ready       in   1          consumer accepts
//  out_data        out  16         head of FIFO
//  fill_level      out  FIFO_AW+1  words stored
//  frame_busy      out  1          frame in progress
//  frame_done      out  1          1-cycle pulse, last page complete
//  overflow        out  1          sticky: write arrived while FIFO full
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, counters 0, rowaddr 0.
//  FSM IDLE -> (frame_start) LOAD; LOAD -> DONE if frame_pages==0, else WAIT.
//  WAIT -> REQ when rd_enable && (DEPTH - fill_level) >= PAGE_WORDS.
//  REQ: cmd_pageread=1 (registered) held until cmd_ack. On ack: rowaddr+1, pages_issued+1 -> BUSY.
//  BUSY: wait cmd_done; then DONE if pages_issued==frame_pages, else WAIT.
//  DONE: frame_done=1 for one cycle, frame_busy=0 -> IDLE.
//  frame_busy=1 from the cycle after frame_start until the DONE cycle.
//  frame_start outside IDLE is ignored. A frame_start in IDLE clears overflow.
//  rowaddr wraps from 2^ROW_W-1 to 0; no error is flagged.
//  rd_enable low mid-page: the current page completes; the FSM parks in WAIT.
//  FIFO is first-word-fall-through:
//   - Write-to-out_valid latency is 1 cycle.
//   - Pop occurs on out_valid && out_ready.
//   - out_data is stable while out_valid && !out_ready.
//  Full FIFO with a write and no pop: word dropped, overflow set.
//  Full FIFO with a write and a pop: both take effect, level unchanged.
//  Empty FIFO with a write: accepted; out_valid is not asserted that cycle.
//  ctrl_fifo_write is accepted in any state, including data after cmd_done.
//  Reset mid-frame aborts immediately; buffered data is discarded.
// TESTING
//  1 start_row=0x10, frame_pages=3, ready=1:
//    -> rowaddr acks 0x10,0x11,0x12; 1536 words out in order; one frame_done.
//  2 out_ready=0, frame_pages=8:
//    -> 4 pages requested (fill 2048); no 5th cmd_pageread until >=512 words popped.
//  3 Force 2049 writes with ready=0 -> overflow=1, fill_level=2048, first 2048 intact.
//  4 frame_pages=0 -> frame_done 2 cycles after frame_start; cmd_pageread never high.
//  5 start_row=0x7FFF, frame_pages=2 -> rows 0x7FFF then 0x0000.
//  6 reset during BUSY of page 2 -> all outputs 0 next cycle; new frame runs clean.

Source files
------------

// File: rtl/sdram_page_reader.sv
// Read-side page negotiator: requests SDRAM page reads for one frame and buffers
// the returned words in a first-word-fall-through FIFO feeding a valid/ready pipe.
module sdram_page_reader #(
  parameter int PAGE_WORDS = 512,
  parameter int ROW_W      = 15,
  parameter int FIFO_AW    = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [ROW_W-1:0]   start_row,
  input  logic [15:0]        frame_pages,
  input  logic               rd_enable,
  output logic               cmd_pageread,
  input  logic               cmd_ack,
  input  logic               cmd_done,
  output logic [ROW_W-1:0]   rowaddr,
  input  logic               ctrl_fifo_write,
  input  logic [15:0]        ctrl_fifo_din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_data,
  output logic [FIFO_AW:0]   fill_level,
  output logic               frame_busy,
  output logic               frame_done,
  output logic               overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_W   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   PAGE_W    = (FIFO_AW + 1)'(PAGE_WORDS);
  localparam logic [FIFO_AW:0]   COUNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE   = {{(FIFO_AW - 1){1'b0}}, 1'b1};
  localparam logic [ROW_W-1:0]   ROW_ONE   = {{(ROW_W - 1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_WAIT, ST_REQ, ST_BUSY, ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic               cmd_reg;
  logic [ROW_W-1:0]   row_reg;
  logic [15:0]        pages_total_reg;
  logic [15:0]        pages_issued_reg;
  logic               overflow_reg;

  logic [15:0]        mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [FIFO_AW:0]   count_reg;
  logic [FIFO_AW:0]   free_words;
  logic [15:0]        rd_data_reg, bypass_data_reg;
  logic               bypass_reg;
  logic               full, pop, wr_en;

  // ---------------- frame sequencing ----------------
  assign free_words = DEPTH_W - count_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (frame_start) state_next = ST_LOAD;
      ST_LOAD: state_next = (pages_total_reg == 16'd0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (rd_enable && (free_words >= PAGE_W)) state_next = ST_REQ;
      ST_REQ:  if (cmd_ack) state_next = ST_BUSY;
      ST_BUSY: if (cmd_done)
                 state_next = (pages_issued_reg == pages_total_reg) ? ST_DONE : ST_WAIT;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cmd_reg          <= 1'b0;
      row_reg          <= '0;
      pages_total_reg  <= '0;
      pages_issued_reg <= '0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= (state_next == ST_REQ);
      if (state_reg == ST_IDLE && frame_start) begin
        row_reg          <= start_row;
        pages_total_reg  <= frame_pages;
        pages_issued_reg <= '0;
      end else if (state_reg == ST_REQ && cmd_ack) begin
        // Row counter wraps naturally at 2^ROW_W.
        row_reg          <= row_reg + ROW_ONE;
        pages_issued_reg <= pages_issued_reg + 16'd1;
      end
    end
  end

  assign cmd_pageread = cmd_reg;
  assign rowaddr      = row_reg;
  assign frame_done   = (state_reg == ST_DONE);
  assign frame_busy   = (state_reg == ST_LOAD) || (state_reg == ST_WAIT) ||
                        (state_reg == ST_REQ)  || (state_reg == ST_BUSY);

  // ---------------- FWFT FIFO ----------------
  assign full      = (count_reg == DEPTH_W);
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes a write when the head is popped the same cycle.
  assign wr_en     = ctrl_fifo_write && (!full || pop);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (pop) rd_ptr_next = rd_ptr_reg + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= ctrl_fifo_din;
  end

  // Read one entry ahead; a write landing on the next head address bypasses the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg     <= '0;
      bypass_data_reg <= '0;
      bypass_reg      <= 1'b0;
    end else begin
      rd_data_reg     <= mem[rd_ptr_next];
      bypass_data_reg <= ctrl_fifo_din;
      bypass_reg      <= wr_en && (wr_ptr_reg == rd_ptr_next);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      rd_ptr_reg <= rd_ptr_next;
      if (wr_en && !pop)      count_reg <= count_reg + COUNT_ONE;
      else if (!wr_en && pop) count_reg <= count_reg - COUNT_ONE;
      if (state_reg == ST_IDLE && frame_start) overflow_reg <= 1'b0;
      if (ctrl_fifo_write && full && !pop)     overflow_reg <= 1'b1;
    end
  end

  assign out_data   = out_valid ? (bypass_reg ? bypass_data_reg : rd_data_reg) : 16'd0;
  assign fill_level = count_reg;
  assign overflow   = overflow_reg;

endmodule
